instr_fetch_queue: RTL and testbench

- Producer side of the decoder's instruction input. Generates the sequential PC and issues aligned 64-bit fetch requests to instruction memory.
- Splits each returned doubleword into two 32-bit RV64I instructions and buffers them in a small FIFO.
- Presents one instruction plus its PC per cycle to the decoder using a valid/ready handshake.
- On redirect (branch, jump or trap), flushes the buffer and refetches from the new PC.

---
 rtl/instr_fetch_queue_if.sv | 31 +++
 rtl/instr_fetch_queue.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bundle: memory request/response, redirect and the
// decoder-facing instruction handshake.
interface instr_fetch_queue_if;
   logic        fetch_req_o;
   logic [63:0] fetch_addr_o;
   logic        fetch_gnt_i;
   logic        fetch_rvalid_i;
   logic [63:0] fetch_rdata_i;
   logic        redirect_i;
   logic [63:0] redirect_pc_i;
   logic [31:0] instr_o;
   logic [63:0] instr_pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i;

   modport master (
      output fetch_req_o, fetch_addr_o,
      input  fetch_gnt_i, fetch_rvalid_i, fetch_rdata_i,
      input  redirect_i, redirect_pc_i,
      output instr_o, instr_pc_o, instr_valid_o,
      input  instr_ready_i
   );

   modport slave (
      input  fetch_req_o, fetch_addr_o,
      output fetch_gnt_i, fetch_rvalid_i, fetch_rdata_i,
      output redirect_i, redirect_pc_i,
      input  instr_o, instr_pc_o, instr_valid_o,
      output instr_ready_i
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher: one outstanding 64-bit request,
// splits doublewords into a small instruction FIFO for the decoder.
module instr_fetch_queue #(
   parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
   parameter int          DEPTH    = 4
) (
   input logic clk,
   input logic rst,
   instr_fetch_queue_if.master bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {REQ, WAIT, DROP} state_e;

   state_e      state_q, state_d;
   logic [63:0] fetch_pc_q, fetch_pc_d;
   logic [63:0] req_pc_q, req_pc_d;
   logic [AW:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr1;
   logic [31:0] instr_q [DEPTH];
   logic [31:0] instr_d [DEPTH];
   logic [63:0] pc_q [DEPTH];
   logic [63:0] pc_d [DEPTH];

   logic       req;
   logic       pop;
   logic       push_en;
   logic [1:0] n_push;
   logic       unused_pc_bits;

   assign unused_pc_bits = ^bus.redirect_pc_i[1:0];

   // Request only while two free slots remain, so a full response fits.
   always_comb begin
      req = (state_q == REQ)
          & (count_q <= (AW+1)'(DEPTH-2))
          & ~bus.redirect_i
          & ~rst;
      pop = (count_q != '0)
          & bus.instr_ready_i
          & ~bus.redirect_i;
      push_en = (state_q == WAIT)
              & bus.fetch_rvalid_i
              & ~bus.redirect_i;
      n_push = 2'd0;
      if (push_en) begin
         n_push = req_pc_q[2] ? 2'd1 : 2'd2;
      end
   end

   assign bus.fetch_req_o   = req;
   assign bus.fetch_addr_o  = {fetch_pc_q[63:3], 3'b000};
   assign bus.instr_valid_o = (count_q != '0);
   assign bus.instr_o       = instr_q[rd_ptr_q];
   assign bus.instr_pc_o    = pc_q[rd_ptr_q];

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      unique case (state_q)
         REQ: begin
            if (req & bus.fetch_gnt_i) begin
               req_pc_d = fetch_pc_q;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (bus.fetch_rvalid_i) begin
               state_d = REQ;
               if (!bus.redirect_i) begin
                  fetch_pc_d = {req_pc_q[63:3], 3'b000}
                             + 64'd8;
               end
            end else if (bus.redirect_i) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (bus.fetch_rvalid_i) begin
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase
      if (bus.redirect_i) begin
         fetch_pc_d = {bus.redirect_pc_i[63:2], 2'b00};
      end
   end

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      wr_ptr1 = wr_ptr_q + 1'b1;
      if (n_push != 2'd0) begin
         instr_d[wr_ptr_q] = req_pc_q[2]
                           ? bus.fetch_rdata_i[63:32]
                           : bus.fetch_rdata_i[31:0];
         pc_d[wr_ptr_q]    = req_pc_q;
      end
      if (n_push == 2'd2) begin
         instr_d[wr_ptr1] = bus.fetch_rdata_i[63:32];
         pc_d[wr_ptr1]    = req_pc_q + 64'd4;
      end
      if (bus.redirect_i) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         count_d  = count_q + (AW+1)'(n_push)
                  - (AW+1)'(pop);
         wr_ptr_d = wr_ptr_q + AW'(n_push);
         rd_ptr_d = rd_ptr_q + AW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= REQ;
         fetch_pc_q <= PC_RESET;
         req_pc_q   <= PC_RESET;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (rst)
      count_q <= (AW+1)'(DEPTH)
   );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus a randomized
// run against a transaction-level fetch/queue model.
module tb_instr_fetch_queue;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   instr_fetch_queue_if b();
   instr_fetch_queue_if w();

   instr_fetch_queue #(
      .PC_RESET(64'h0000_0000_8000_0000),
      .DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(b.master)
   );

   instr_fetch_queue #(
      .PC_RESET(64'hFFFF_FFFF_FFFF_FFF8),
      .DEPTH(4)
   ) dut_w (
      .clk(clk),
      .rst(rst),
      .bus(w.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      b.fetch_gnt_i    = 1'b0;
      b.fetch_rvalid_i = 1'b0;
      b.fetch_rdata_i  = '0;
      b.redirect_i     = 1'b0;
      b.redirect_pc_i  = '0;
      b.instr_ready_i  = 1'b0;
      w.fetch_gnt_i    = 1'b0;
      w.fetch_rvalid_i = 1'b0;
      w.fetch_rdata_i  = '0;
      w.redirect_i     = 1'b0;
      w.redirect_pc_i  = '0;
      w.instr_ready_i  = 1'b0;
   endtask

   // grant the pending request, then answer next cycle
   task automatic fetch_b(input logic [63:0] data);
      b.fetch_gnt_i = 1'b1;
      step();
      b.fetch_gnt_i    = 1'b0;
      b.fetch_rvalid_i = 1'b1;
      b.fetch_rdata_i  = data;
      step();
      b.fetch_rvalid_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_all();
      step();
      checks++; if (b.fetch_req_o !== 1'b0) begin failures++; $display("FAIL rst_req act=%0b exp=0", b.fetch_req_o); end
      checks++; if (b.instr_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid act=%0b exp=0", b.instr_valid_o); end
      checks++; if (b.fetch_addr_o !== 64'h8000_0000) begin failures++; $display("FAIL rst_addr act=%h exp=80000000", b.fetch_addr_o); end
      checks++; if (w.fetch_addr_o !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL rst_addr_w act=%h", w.fetch_addr_o); end
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_basic();
      checks++; if (b.fetch_req_o !== 1'b1) begin failures++; $display("FAIL basic_req act=%0b exp=1", b.fetch_req_o); end
      checks++; if (b.fetch_addr_o !== 64'h8000_0000) begin failures++; $display("FAIL basic_addr act=%h exp=80000000", b.fetch_addr_o); end
      b.fetch_gnt_i = 1'b1;
      step();
      b.fetch_gnt_i = 1'b0;
      #1;
      checks++; if (b.fetch_req_o !== 1'b0) begin failures++; $display("FAIL basic_wait_req act=%0b exp=0", b.fetch_req_o); end
      b.fetch_rvalid_i = 1'b1;
      b.fetch_rdata_i  = 64'h00A0_0093_0050_0013;
      step();
      b.fetch_rvalid_i = 1'b0;
      b.instr_ready_i  = 1'b1;
      #1;
      checks++; if (b.instr_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid act=%0b exp=1", b.instr_valid_o); end
      checks++; if (b.instr_o !== 32'h0050_0013) begin failures++; $display("FAIL basic_i0 act=%h exp=00500013", b.instr_o); end
      checks++; if (b.instr_pc_o !== 64'h8000_0000) begin failures++; $display("FAIL basic_pc0 act=%h exp=80000000", b.instr_pc_o); end
      checks++; if (b.fetch_addr_o !== 64'h8000_0008) begin failures++; $display("FAIL basic_next act=%h exp=80000008", b.fetch_addr_o); end
      checks++; if (b.fetch_req_o !== 1'b1) begin failures++; $display("FAIL basic_req2 act=%0b exp=1", b.fetch_req_o); end
      step();
      checks++; if (b.instr_o !== 32'h00A0_0093) begin failures++; $display("FAIL basic_i1 act=%h exp=00a00093", b.instr_o); end
      checks++; if (b.instr_pc_o !== 64'h8000_0004) begin failures++; $display("FAIL basic_pc1 act=%h exp=80000004", b.instr_pc_o); end
      step();
      b.instr_ready_i = 1'b0;
      #1;
      checks++; if (b.instr_valid_o !== 1'b0) begin failures++; $display("FAIL basic_empty act=%0b exp=0", b.instr_valid_o); end
   endtask

   task automatic test_redirect_req();
      b.redirect_i    = 1'b1;
      b.redirect_pc_i = 64'h8000_0104;
      b.fetch_gnt_i   = 1'b1;
      #1;
      checks++; if (b.fetch_req_o !== 1'b0) begin failures++; $display("FAIL rreq_req act=%0b exp=0", b.fetch_req_o); end
      step();
      b.redirect_i  = 1'b0;
      b.fetch_gnt_i = 1'b0;
      #1;
      checks++; if (b.fetch_addr_o !== 64'h8000_0100) begin failures++; $display("FAIL rreq_addr act=%h exp=80000100", b.fetch_addr_o); end
      checks++; if (b.fetch_req_o !== 1'b1) begin failures++; $display("FAIL rreq_req2 act=%0b exp=1", b.fetch_req_o); end
      fetch_b({32'h1111_1111, 32'h2222_2222});
      checks++; if (b.instr_o !== 32'h1111_1111) begin failures++; $display("FAIL rreq_instr act=%h exp=11111111", b.instr_o); end
      checks++; if (b.instr_pc_o !== 64'h8000_0104) begin failures++; $display("FAIL rreq_pc act=%h exp=80000104", b.instr_pc_o); end
      b.instr_ready_i = 1'b1;
      step();
      b.instr_ready_i = 1'b0;
      #1;
      checks++; if (b.instr_valid_o !== 1'b0) begin failures++; $display("FAIL rreq_one act=%0b exp=0", b.instr_valid_o); end
      checks++; if (b.fetch_addr_o !== 64'h8000_0108) begin failures++; $display("FAIL rreq_next act=%h exp=80000108", b.fetch_addr_o); end
   endtask

   task automatic test_redirect_wait();
      b.fetch_gnt_i = 1'b1;
      step();
      b.fetch_gnt_i   = 1'b0;
      b.redirect_i    = 1'b1;
      b.redirect_pc_i = 64'h8000_0200;
      step();
      b.redirect_i = 1'b0;
      #1;
      checks++; if (b.fetch_req_o !== 1'b0) begin failures++; $display("FAIL rwait_drop_req act=%0b exp=0", b.fetch_req_o); end
      step();
      step();
      b.fetch_rvalid_i = 1'b1;
      b.fetch_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      checks++; if (b.fetch_req_o !== 1'b0) begin failures++; $display("FAIL rwait_req3 act=%0b exp=0", b.fetch_req_o); end
      step();
      b.fetch_rvalid_i = 1'b0;
      #1;
      checks++; if (b.instr_valid_o !== 1'b0) begin failures++; $display("FAIL rwait_nopush act=%0b exp=0", b.instr_valid_o); end
      checks++; if (b.fetch_req_o !== 1'b1) begin failures++; $display("FAIL rwait_req act=%0b exp=1", b.fetch_req_o); end
      checks++; if (b.fetch_addr_o !== 64'h8000_0200) begin failures++; $display("FAIL rwait_addr act=%h exp=80000200", b.fetch_addr_o); end
      fetch_b({32'hAAAA_0001, 32'hAAAA_0000});
      checks++; if (b.instr_o !== 32'hAAAA_0000) begin failures++; $display("FAIL rwait_instr act=%h exp=aaaa0000", b.instr_o); end
      checks++; if (b.instr_pc_o !== 64'h8000_0200) begin failures++; $display("FAIL rwait_pc act=%h exp=80000200", b.instr_pc_o); end
   endtask

   task automatic test_full();
      checks++; if (b.fetch_req_o !== 1'b1) begin failures++; $display("FAIL full_req2 act=%0b exp=1", b.fetch_req_o); end
      fetch_b({32'hBBBB_0001, 32'hBBBB_0000});
      checks++; if (b.fetch_req_o !== 1'b0) begin failures++; $display("FAIL full_req4 act=%0b exp=0", b.fetch_req_o); end
      checks++; if (b.instr_o !== 32'hAAAA_0000) begin failures++; $display("FAIL full_head act=%h exp=aaaa0000", b.instr_o); end
      b.fetch_gnt_i = 1'b1;
      step();
      step();
      b.fetch_gnt_i = 1'b0;
      #1;
      checks++; if (b.fetch_req_o !== 1'b0) begin failures++; $display("FAIL full_hold act=%0b exp=0", b.fetch_req_o); end
      b.instr_ready_i = 1'b1;
      step();
      b.instr_ready_i = 1'b0;
      #1;
      checks++; if (b.fetch_req_o !== 1'b0) begin failures++; $display("FAIL full_req3 act=%0b exp=0", b.fetch_req_o); end
      checks++; if (b.instr_o !== 32'hAAAA_0001) begin failures++; $display("FAIL full_head3 act=%h exp=aaaa0001", b.instr_o); end
      b.instr_ready_i = 1'b1;
      step();
      b.instr_ready_i = 1'b0;
      #1;
      checks++; if (b.fetch_req_o !== 1'b1) begin failures++; $display("FAIL full_resume act=%0b exp=1", b.fetch_req_o); end
      checks++; if (b.fetch_addr_o !== 64'h8000_0210) begin failures++; $display("FAIL full_addr act=%h exp=80000210", b.fetch_addr_o); end
      checks++; if (b.instr_pc_o !== 64'h8000_0208) begin failures++; $display("FAIL full_pc act=%h exp=80000208", b.instr_pc_o); end
   endtask

   task automatic test_same_cycle();
      b.fetch_gnt_i = 1'b1;
      step();
      b.fetch_gnt_i    = 1'b0;
      b.redirect_i     = 1'b1;
      b.redirect_pc_i  = 64'h8000_0306;
      b.fetch_rvalid_i = 1'b1;
      b.fetch_rdata_i  = 64'hCCCC_CCCC_CCCC_CCCC;
      b.instr_ready_i  = 1'b1;
      step();
      b.redirect_i     = 1'b0;
      b.fetch_rvalid_i = 1'b0;
      b.instr_ready_i  = 1'b0;
      #1;
      checks++; if (b.instr_valid_o !== 1'b0) begin failures++; $display("FAIL same_valid act=%0b exp=0", b.instr_valid_o); end
      checks++; if (b.fetch_req_o !== 1'b1) begin failures++; $display("FAIL same_req act=%0b exp=1", b.fetch_req_o); end
      checks++; if (b.fetch_addr_o !== 64'h8000_0300) begin failures++; $display("FAIL same_addr act=%h exp=80000300", b.fetch_addr_o); end
      fetch_b({32'hDDDD_0001, 32'hDDDD_0000});
      checks++; if (b.instr_o !== 32'hDDDD_0001) begin failures++; $display("FAIL same_instr act=%h exp=dddd0001", b.instr_o); end
      checks++; if (b.instr_pc_o !== 64'h8000_0304) begin failures++; $display("FAIL same_pc act=%h exp=80000304", b.instr_pc_o); end
      b.instr_ready_i = 1'b1;
      step();
      b.instr_ready_i = 1'b0;
      #1;
   endtask

   task automatic test_wrap();
      checks++; if (w.fetch_req_o !== 1'b1) begin failures++; $display("FAIL wrap_req act=%0b exp=1", w.fetch_req_o); end
      w.fetch_gnt_i = 1'b1;
      step();
      w.fetch_gnt_i    = 1'b0;
      w.fetch_rvalid_i = 1'b1;
      w.fetch_rdata_i  = {32'h0000_0113, 32'h0000_0093};
      step();
      w.fetch_rvalid_i = 1'b0;
      w.instr_ready_i  = 1'b1;
      #1;
      checks++; if (w.instr_pc_o !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL wrap_pc0 act=%h", w.instr_pc_o); end
      checks++; if (w.instr_o !== 32'h0000_0093) begin failures++; $display("FAIL wrap_i0 act=%h exp=00000093", w.instr_o); end
      step();
      checks++; if (w.instr_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_pc1 act=%h", w.instr_pc_o); end
      checks++; if (w.instr_o !== 32'h0000_0113) begin failures++; $display("FAIL wrap_i1 act=%h exp=00000113", w.instr_o); end
      step();
      w.instr_ready_i = 1'b0;
      #1;
      checks++; if (w.instr_valid_o !== 1'b0) begin failures++; $display("FAIL wrap_empty act=%0b exp=0", w.instr_valid_o); end
      checks++; if (w.fetch_addr_o !== 64'h0) begin failures++; $display("FAIL wrap_addr act=%h exp=0", w.fetch_addr_o); end
   endtask

   // Model: a queue of expected {instr,pc}, the next fetch PC, and
   // whether one request is outstanding and already cancelled.
   task automatic test_random();
      logic [63:0] m_pc;
      logic [63:0] m_req;
      logic [63:0] al;
      logic [63:0] rpc;
      logic [95:0] q[$];
      logic [95:0] hd;
      bit          m_out;
      bit          m_drop;
      bit          rd, rv, gn, rdy, exp_req;
      int          lat;
      m_pc   = 64'h8000_0308;
      m_req  = '0;
      m_out  = 1'b0;
      m_drop = 1'b0;
      lat    = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rd  = ($urandom_range(0, 15) == 0);
         rpc = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rpc[63:4] = '1;
         rdy = ($urandom_range(0, 2) != 0);
         gn  = ($urandom_range(0, 1) == 1);
         rv  = m_out && (lat == 0);
         al  = {m_req[63:3], 3'b000};
         b.redirect_i     = rd;
         b.redirect_pc_i  = rpc;
         b.instr_ready_i  = rdy;
         b.fetch_gnt_i    = gn;
         b.fetch_rvalid_i = rv;
         b.fetch_rdata_i  = rv ? {word_at(al + 64'd4), word_at(al)}
                               : {$urandom, $urandom};
         #1;
         exp_req = !m_out && (q.size() <= 2) && !rd;
         checks++; if (b.fetch_req_o !== exp_req) begin failures++; $display("FAIL rnd_req cyc=%0d act=%0b exp=%0b", cyc, b.fetch_req_o, exp_req); end
         checks++; if (b.fetch_addr_o !== {m_pc[63:3], 3'b000}) begin failures++; $display("FAIL rnd_addr cyc=%0d act=%h exp=%h", cyc, b.fetch_addr_o, {m_pc[63:3], 3'b000}); end
         checks++; if (b.instr_valid_o !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d act=%0b exp=%0b", cyc, b.instr_valid_o, q.size() != 0); end
         if (q.size() != 0) begin
            hd = q[0];
            checks++; if ({b.instr_o, b.instr_pc_o} !== hd) begin failures++; $display("FAIL rnd_head cyc=%0d act=%h/%h exp=%h/%h", cyc, b.instr_o, b.instr_pc_o, hd[95:64], hd[63:0]); end
         end
         if (m_out && !rv) lat--;
         if (rd) begin
            q.delete();
            m_pc = {rpc[63:2], 2'b00};
            if (m_out) begin
               if (rv) begin
                  m_out  = 1'b0;
                  m_drop = 1'b0;
               end else begin
                  m_drop = 1'b1;
               end
            end
         end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (rv) begin
               m_out = 1'b0;
               if (!m_drop) begin
                  for (int k = 0; k < (m_req[2] ? 1 : 2); k++) begin
                     q.push_back({word_at(m_req + 64'(4*k)), m_req + 64'(4*k)});
                  end
                  m_pc = al + 64'd8;
               end
               m_drop = 1'b0;
            end else if (exp_req && gn) begin
               m_out = 1'b1;
               m_req = m_pc;
               lat   = $urandom_range(0, 3);
            end
         end
         step();
      end
      idle_all();
   endtask

   initial begin
      idle_all();
      rst = 1'b1;
      test_reset();
      test_basic();
      test_redirect_req();
      test_redirect_wait();
      test_full();
      test_same_cycle();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
